// File: rtl/pxconv_arb_pkg.sv
// Shared types and AXI constants for the pixel-converter read arbiter.
package pxconv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [2:0] ARPROT_DEF   = 3'b000;
  localparam logic [3:0] ARCACHE_DEF  = 4'b0011;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  // One-hot select for a 2-requester index.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pxconv_rd_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, registered last-grant pointer.
module pxconv_rr_arb2
  import pxconv_arb_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       grant,
  output logic       any
);

  // Index of the requester granted most recently; reset to 1 so requester 0 wins first.
  logic last_reg;

  assign any = |req;

  // Winner selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b10) begin
      grant = 1'b1;
    end else if (req == 2'b11) begin
      grant = ~last_reg;
    end
  end

  // Remember who was granted whenever the parent commits to a grant.
  always_ff @(posedge clk) begin
    if (srst) begin
      last_reg <= 1'b1;
    end else if (take && any) begin
      last_reg <= grant;
    end
  end

endmodule

// File: rtl/pxconv_rd_arbiter.sv
// Read arbiter: shares one AXI4 read master between the BRAM loader (0) and the
// pixel converter (1), one burst outstanding at a time.
// Optional burst-length checking is enabled by defining PXCONV_ARB_LEN_CHECK_EN.
module pxconv_rd_arbiter
  import pxconv_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_areset,

  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [7:0]        req_len0,
  input  logic [7:0]        req_len1,

  output logic [1:0]        rd_valid,
  input  logic [1:0]        rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,

  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arcache,

  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,

  output logic              md_error
);

  arb_state_t        state_reg;
  arb_state_t        state_next;
  logic              grant_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        len_reg;
  logic              md_error_reg;

  logic              win;
  logic              any;
  logic              take;
  logic              beat_ok;
  logic              len_err;

  // A grant is committed only from IDLE, which guarantees one idle cycle between bursts.
  assign take    = (state_reg == ST_IDLE) && any;
  assign beat_ok = (state_reg == ST_DATA) && m_axi_rvalid && m_axi_rready;

  pxconv_rr_arb2 u_rr (
    .clk   (m_axi_aclk),
    .srst  (m_axi_areset),
    .req   (req_valid),
    .take  (take),
    .grant (win),
    .any   (any)
  );

`ifdef PXCONV_ARB_LEN_CHECK_EN
  logic [7:0] beat_cnt_reg;

  // Flag rlast arriving early, or the expected last beat arriving without rlast.
  assign len_err = beat_ok && (m_axi_rlast != (beat_cnt_reg == len_reg));

  // Count accepted beats of the current burst; cleared at every burst boundary.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset || take || (beat_ok && m_axi_rlast)) begin
      beat_cnt_reg <= 8'd0;
    end else if (beat_ok) begin
      beat_cnt_reg <= beat_cnt_reg + 8'd1;
    end
  end
`else
  assign len_err = 1'b0;
`endif

  // State, latched request and sticky error register.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= 1'b0;
      addr_reg     <= '0;
      len_reg      <= 8'd0;
      md_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        grant_reg <= win;
        addr_reg  <= win ? req_addr1 : req_addr0;
        len_reg   <= win ? req_len1 : req_len0;
      end
      if (beat_ok && ((m_axi_rresp != RESP_OKAY) || len_err)) begin
        md_error_reg <= 1'b1;
      end
    end
  end

  // Next-state and handshake/routing outputs; everything idle outside its phase.
  always_comb begin
    state_next    = state_reg;
    m_axi_arvalid = 1'b0;
    req_ready     = 2'b00;
    m_axi_rready  = 1'b0;
    rd_valid      = 2'b00;
    rd_last       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (any) begin
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          req_ready  = onehot2(grant_reg);
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        rd_valid     = m_axi_rvalid ? onehot2(grant_reg) : 2'b00;
        m_axi_rready = rd_ready[grant_reg];
        rd_last      = m_axi_rlast;
        if (m_axi_rvalid && rd_ready[grant_reg] && m_axi_rlast) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rd_data       = m_axi_rdata;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = len_reg;
  assign m_axi_arsize  = ARSIZE_4B;
  assign m_axi_arburst = ARBURST_INCR;
  assign m_axi_arprot  = ARPROT_DEF;
  assign m_axi_arcache = ARCACHE_DEF;
  assign md_error      = md_error_reg;

endmodule

// File: doc/pxconv_rd_arbiter.md
PXCONV_RD_ARBITER -- requirements
Module: pxconv_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width of requests and m_axi_araddr.
REQ-002 SHALL have parameter DATA_W, 32, width of m_axi_rdata and rd_data.
REQ-003 SHALL have port m_axi_aclk  in  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port m_axi_areset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  in  2  per-requester burst request (bit 0 = BRAM loader, bit 1 = pixel converter).
REQ-006 SHALL have port req_ready  out  2  one-cycle accept pulse to the granted requester.
REQ-007 SHALL have port req_addr0 / req_addr1  in  ADDR_W  each  burst start byte address.
REQ-008 SHALL have port req_len0 / req_len1  in  8  each  beats minus one (AXI arlen encoding).
REQ-009 SHALL have port rd_valid  out  2  read beat valid, routed to the granted requester only.
REQ-010 SHALL have port rd_ready  in  2  requester beat acceptance.
REQ-011 SHALL have port rd_data  out  DATA_W  beat data shared by both requesters.
REQ-012 SHALL have port rd_last  out  1  final beat of the current burst.
REQ-013 SHALL have the AXI4 read master ports m_axi_arvalid/arready/araddr[ADDR_W]/arlen[8]/arsize[3]/arburst[2]/arprot[3]/arcache[4] and m_axi_rvalid/rready/rdata[DATA_W]/rresp[2]/rlast, directions per AXI4 master.
REQ-014 SHALL have port md_error  out  1  sticky error flag.

Function
REQ-015 SHALL implement states IDLE, ADDR, DATA; exactly one burst outstanding.
REQ-016 IDLE: if any req_valid, SHALL latch the winner's addr/len and go to ADDR next cycle.
REQ-017 Arbitration SHALL be round-robin: single requester wins; both valid -> the requester not granted last; after reset, requester 0 has priority.
REQ-018 ADDR: m_axi_arvalid SHALL be 1 with latched araddr/arlen; arvalid and address SHALL stay stable until m_axi_arready.
REQ-019 On AR handshake SHALL pulse req_ready[grant] for exactly that cycle and enter DATA.
REQ-020 Constant outputs: arsize 3'b010, arburst 2'b01 (INCR), arprot 3'b000, arcache 4'b0011.
REQ-021 DATA: rd_valid[grant] = m_axi_rvalid, m_axi_rready = rd_ready[grant], rd_data = m_axi_rdata, rd_last = m_axi_rlast, all combinational (zero latency); non-granted rd_valid bit SHALL be 0.
REQ-022 Beat accepted (rvalid and rready) with m_axi_rlast SHALL return to IDLE next cycle; a new grant takes at least one IDLE cycle.
REQ-023 Outside DATA, m_axi_rready SHALL be 0 and rd_valid SHALL be 0.
REQ-024 Accepted beat with rresp != 2'b00 SHALL set md_error; beat still forwarded.
REQ-025 req_valid dropped while in ADDR SHALL NOT abort the burst (request already latched).
REQ-026 md_error SHALL clear only on reset.

Reset
REQ-027 Reset asserted (including mid-burst) SHALL force IDLE, grant pointer to requester 0, beat counter 0, md_error 0, arvalid 0, rready 0, req_ready 0, rd_valid 0; no output depends on pre-reset history.

Configuration
REQ-028 Macro PXCONV_ARB_LEN_CHECK_EN defined: 8-bit beat counter SHALL compare against latched len; rlast before beat len+1, or beat len+1 without rlast, SHALL set md_error; burst ends on rlast in both cases.
REQ-029 Macro undefined: no beat counter; burst end determined solely by m_axi_rlast; md_error set only by rresp.

Structure
REQ-030 Package pxconv_arb_pkg SHALL hold the state enum typedef and the constants ARSIZE_4B, ARBURST_INCR, ARPROT_DEF, ARCACHE_DEF, RESP_OKAY.
REQ-031 Sub-module pxconv_rr_arb2 SHALL hold the 2-way round-robin grant logic and pointer.

Verification
REQ-032 Only req_valid=2'b01, addr 0x1000, len 3; slave arready=1 -> araddr 0x1000, arlen 3, req_ready=2'b01 one cycle, 4 beats on rd_valid[0], IDLE after rlast.
REQ-033 Both valid from reset (addr0 0x0, addr1 0x2000, len 0) -> grant order 0,1,0,1 over four bursts.
REQ-034 arready held 0 for 5 cycles -> arvalid, araddr, arlen stable for all 5; req_ready pulses only on handshake.
REQ-035 rd_ready[0] toggled 1,0,1 during 4-beat burst -> m_axi_rready mirrors it; no beat lost or duplicated; rd_valid[1] stays 0.
REQ-036 rresp 2'b10 on beat 2 -> md_error=1 and stays set until reset; with PXCONV_ARB_LEN_CHECK_EN, len 3 with rlast on beat 2 -> md_error=1.
REQ-037 Reset asserted during DATA beat 2 -> next cycle IDLE, all outputs at reset values; fresh request from requester 1 then served normally.
